countdown_timer_ctrl: RTL
=========================

// Module: countdown_timer_ctrl
// PURPOSE
//  MM:SS countdown controller for the game timer. Sequences an internal 1 Hz tick enable
//  (no derived clocks), loads a BCD preset, runs, pauses, resumes and flags expiry.
//  Feeds the 7-seg display driver (DIGITS) and game FSM (DONE/EXPIRED). All in CLK100M domain.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency
//  TICK_HZ    1            countdown rate; tick period P = CLK_HZ/TICK_HZ cycles (integer, >=2)
//  RESET_BCD  16'h0100     MM:SS value loaded on RESET (01:00)
// PORTS
//  CLK100M     in   1   system clock, all logic on posedge
//  RESET       in   1   synchronous, active-high
//  LOAD        in   1   1-cycle pulse: load PRESET_BCD, go IDLE
//  PRESET_BCD  in   16  {m_tens,m_ones,s_tens,s_ones}, 4 bits each
//  START       in   1   1-cycle pulse: IDLE->RUN
//  PAUSE       in   1   1-cycle pulse: toggles RUN<->PAUSED
//  DIGITS      out  16  current MM:SS BCD, registered
//  RUNNING     out  1   1 while in RUN
//  DONE        out  1   1-cycle pulse on reaching 00:00
//  EXPIRED     out  1   level, 1 in EXPIRED state
//  LOAD_ERR    out  1   1-cycle pulse when LOAD rejected
// BEHAVIOUR
//  - RESET: state IDLE, DIGITS=RESET_BCD, prescaler=0, RUNNING/DONE/EXPIRED/LOAD_ERR=0.
//  - States: IDLE, RUN, PAUSED, EXPIRED. Priority per cycle: RESET > LOAD > START > PAUSE.
//  - LOAD (any state): if every digit <=9 and s_tens <=5, DIGITS<=PRESET_BCD, prescaler<=0,
//    state<=IDLE next cycle; else DIGITS/state unchanged, LOAD_ERR=1 next cycle.
//  - IDLE: START with DIGITS!=0000 -> RUN, prescaler cleared; START at 00:00 ignored.
//  - RUN: prescaler counts 0..P-1, tick on P-1 then wraps to 0. First decrement is exactly P
//    cycles after RUNNING rises. Tick decrements DIGITS with BCD borrow:
//    s_ones 0->9 borrows s_tens; s_tens 0->5 borrows m_ones; m_ones 0->9 borrows m_tens.
//  - Tick taking DIGITS 00:01->00:00: same edge state<=EXPIRED, DONE=1 for one cycle, EXPIRED=1.
//  - PAUSE in RUN -> PAUSED, prescaler holds its value; PAUSE in PAUSED -> RUN, resumes count
//    (partial second preserved). PAUSE in IDLE/EXPIRED ignored. START in RUN/PAUSED ignored.
//  - Tick and PAUSE same cycle: decrement applied, then PAUSED. Tick to 00:00 and PAUSE same
//    cycle: EXPIRED wins, DONE pulses.
//  - EXPIRED: DIGITS hold 0000; leave only via LOAD or RESET.
//  - RESET mid-run: abandons count, returns to RESET_BCD, no DONE.
//  - All outputs registered; input-to-output latency 1 cycle.
// STRUCTURE
//  - Shared package timer_pkg: state encoding (2-bit), BCD_MAX=4'd9, SEC_TENS_MAX=4'd5,
//    PRESCALE width function clog2(CLK_HZ/TICK_HZ).
//  - Sub-module tick_gen (CLK100M, RESET, en, clr -> tick): prescaler, holds when en=0,
//    clr synchronous. Controller holds FSM, BCD borrow chain and validation.
// TESTING (bench uses CLK_HZ=10, TICK_HZ=1 -> P=10)
//  - RESET -> DIGITS=0100, RUNNING=0; START -> RUNNING=1 next cycle, DIGITS=0059 10 cycles later.
//  - LOAD 0010, START, run 100 cycles -> DIGITS 0000, DONE one pulse, EXPIRED=1, START ignored.
//  - LOAD 1000, START, 10 cycles -> 0959 (m_tens borrow), then 0958 after 10 more.
//  - RUN 4 cycles, PAUSE, wait 50, PAUSE -> next decrement 6 cycles after resume.
//  - LOAD 0160 (s_tens=6) and LOAD 0A00 -> LOAD_ERR pulse each, DIGITS/state unchanged.
//  - RESET asserted mid-RUN, and LOAD+START same cycle -> RESET_BCD/IDLE resp. loaded+IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, BCD limits and helpers for the countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    function automatic int prescale_width(input int clk_hz, input int tick_hz);
        int w;
        w = $clog2(clk_hz / tick_hz);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[15:12] <= BCD_MAX) && (v[11:8] <= BCD_MAX) &&
               (v[7:4] <= SEC_TENS_MAX) && (v[3:0] <= BCD_MAX);
    endfunction

    // One-second decrement of a non-zero MM:SS value, borrowing digit by digit
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = BCD_MAX;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = SEC_TENS_MAX;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = BCD_MAX;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// rtl/countdown_timer_ctrl_if.sv - control/status bundle between game logic and the countdown timer
interface countdown_timer_ctrl_if;

    logic        LOAD;
    logic [15:0] PRESET_BCD;
    logic        START;
    logic        PAUSE;
    logic [15:0] DIGITS;
    logic        RUNNING;
    logic        DONE;
    logic        EXPIRED;
    logic        LOAD_ERR;

    modport master (
        output LOAD, PRESET_BCD, START, PAUSE,
        input  DIGITS, RUNNING, DONE, EXPIRED, LOAD_ERR
    );

    modport slave (
        input  LOAD, PRESET_BCD, START, PAUSE,
        output DIGITS, RUNNING, DONE, EXPIRED, LOAD_ERR
    );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick enable every CLK_HZ/TICK_HZ enabled cycles
module tick_gen
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic CLK100M,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int           P    = CLK_HZ / TICK_HZ;
    localparam int           W    = prescale_width(CLK_HZ, TICK_HZ);
    localparam logic [W-1:0] LAST = W'(P - 1);

    logic [W-1:0] count;

    // Holding while en is low is what preserves a partial second across a pause
    always_ff @(posedge CLK100M) begin
        if (RESET || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - MM:SS countdown FSM with BCD preset validation and expiry flagging
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TICK_HZ   = 1,
    parameter logic [15:0] RESET_BCD = 16'h0100
) (
    input  logic                    CLK100M,
    input  logic                    RESET,
    countdown_timer_ctrl_if.slave   bus
);

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic        running_q, done_q, expired_q, load_err_q;
    logic        done_d, load_err_d;
    logic        en, clr, tick;

    // A LOAD cycle, accepted or rejected, consumes the cycle: the prescaler does not advance
    assign en = (state_q == ST_RUN) && !bus.LOAD;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .CLK100M (CLK100M),
        .RESET   (RESET),
        .en      (en),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        clr        = 1'b0;
        if (bus.LOAD) begin
            if (bcd_valid(bus.PRESET_BCD)) begin
                digits_d = bus.PRESET_BCD;
                state_d  = ST_IDLE;
                clr      = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.START && (digits_q != 16'h0000)) begin
                        state_d = ST_RUN;
                        clr     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        digits_d = bcd_dec(digits_q);
                    end
                    // Expiry outranks a coincident PAUSE
                    if (tick && (digits_q == 16'h0001)) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else if (bus.PAUSE) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK100M) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            digits_q   <= RESET_BCD;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            running_q  <= (state_d == ST_RUN);
            done_q     <= done_d;
            expired_q  <= (state_d == ST_EXPIRED);
            load_err_q <= load_err_d;
        end
    end

    assign bus.DIGITS   = digits_q;
    assign bus.RUNNING  = running_q;
    assign bus.DONE     = done_q;
    assign bus.EXPIRED  = expired_q;
    assign bus.LOAD_ERR = load_err_q;

endmodule
